// File: rtl/dw_conv_krow_sequencer.sv
// dw_conv_krow_sequencer: steps a depthwise-conv kernel row by row, broadcasting each row's
// weights (raw, BPEB-encoded, ETC counts) and sequencing the conv/infm-load/shadow tasks.
module dw_conv_krow_sequencer #(
  parameter int num_pe_row       = 4,
  parameter int num_pe_col       = 4,
  parameter int nb_taps          = 11,
  parameter int weight_width     = 16,
  parameter int weight_bpr_width = 24,
  parameter int ETC_width        = 4,
  parameter int max_kernel_size  = 5,
  parameter int row_width        = 16,
  localparam int depth           = max_kernel_size * max_kernel_size,
  localparam int aw              = $clog2(depth),
  localparam int n_pe            = num_pe_row * num_pe_col
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start_i,
  input  logic [2:0]                                    kernel_size_i,
  input  logic [3:0]                                    n_ap_i,
  input  logic [row_width-1:0]                          infm_start_row_i,
  input  logic                                          w_wr_en_i,
  input  logic [aw-1:0]                                 w_wr_addr_i,
  input  logic [weight_width-1:0]                       w_wr_data_i,
  output logic [num_pe_col*weight_width*nb_taps-1:0]     WRegs_o,
  output logic [num_pe_col*weight_bpr_width*nb_taps-1:0] WBPRs_o,
  output logic [num_pe_col*ETC_width*nb_taps-1:0]        WETCs_o,
  output logic                                          row_conv_start_o,
  output logic                                          row_conv_first_o,
  input  logic                                          row_conv_done_i,
  output logic                                          infm_load_start_o,
  output logic [row_width-1:0]                          infm_load_row_o,
  input  logic                                          infm_load_done_i,
  output logic                                          shadow_start_o,
  output logic [row_width-1:0]                          shadow_row_o,
  input  logic                                          shadow_done_i,
  output logic                                          first_acc_flag_o,
  output logic [n_pe-1:0]                               pe_ctrl_which_afifo_for_compute_o,
  output logic [n_pe-1:0]                               pe_ctrl_compute_AFIFO_read_delay_enable_o,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          error_o
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, LAUNCH, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] krow_q, krow_d, ks_q, ks_d, launched_q, launched_d, got_q, got_d;
  logic [3:0] nap_q, nap_d;
  logic [row_width-1:0] row_q, row_d, sh_row_q, sh_row_d;
  logic [nb_taps-1:0][weight_width-1:0] wtap_q, wtap_d, tap_w;
  logic [nb_taps-1:0][weight_bpr_width-1:0] bpr_q, bpr_d, tap_bpr;
  logic [nb_taps-1:0][ETC_width-1:0] etc_q, etc_d, tap_etc;
  logic which_q, which_d, rde_q, rde_d, first_q, first_d;
  logic conv_start_q, conv_start_d, conv_first_q, conv_first_d, infm_start_q, infm_start_d;
  logic sh_start_q, sh_start_d, done_q, done_d, err_q, err_d;
  logic [weight_width-1:0] store_q [depth];
  logic more_rows;
  logic [2:0] launch_set, task_done;
  // Groups are 3-bit windows over {w,0}; low n_ap groups are forced to 000.
  function automatic logic [ETC_width+weight_bpr_width-1:0] encode(input logic [weight_width-1:0] w,
                                                                   input logic [3:0] nap);
    logic [weight_width:0] wx;
    logic [weight_bpr_width-1:0] b;
    logic [ETC_width-1:0] e;
    logic [2:0] grp;
    wx = {w, 1'b0};
    b = '0;
    e = '0;
    for (int g = 0; g < weight_bpr_width / 3; g++) begin
      grp = wx[2*g +: 3];
      if (g >= int'(nap)) begin
        b[3*g +: 3] = grp;
        e = e + ETC_width'(grp != 3'b000 && grp != 3'b111);
      end
    end
    return {e, b};
  endfunction
  assign more_rows = krow_q < ks_q - 3'd1;
  assign launch_set = {more_rows, krow_q == 3'd0, 1'b1};
  assign task_done = {shadow_done_i, infm_load_done_i, row_conv_done_i};
  always_comb begin
    for (int i = 0; i < nb_taps; i++) begin
      tap_w[i] = (i < int'(ks_q) && int'(krow_q) * int'(ks_q) + i < depth)
               ? store_q[aw'(int'(krow_q) * int'(ks_q) + i)] : '0;
      {tap_etc[i], tap_bpr[i]} = encode(tap_w[i], nap_q);
    end
  end
  always_comb begin
    state_d = state_q; krow_d = krow_q; ks_d = ks_q; nap_d = nap_q; row_d = row_q; sh_row_d = sh_row_q;
    wtap_d = wtap_q; bpr_d = bpr_q; etc_d = etc_q; launched_d = launched_q; got_d = got_q;
    which_d = which_q; rde_d = rde_q; first_d = first_q;
    conv_start_d = 1'b0; conv_first_d = 1'b0; infm_start_d = 1'b0; sh_start_d = 1'b0;
    done_d = 1'b0; err_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (kernel_size_i == 3'd0 || int'(kernel_size_i) > max_kernel_size) err_d = 1'b1;
        else begin
          ks_d = kernel_size_i; nap_d = n_ap_i; row_d = infm_start_row_i; krow_d = 3'd0; state_d = LOAD;
        end
      end
      LOAD: begin
        wtap_d = tap_w; bpr_d = tap_bpr; etc_d = tap_etc;
        which_d = which_q ^ (krow_q != 3'd0);
        rde_d = more_rows;
        first_d = krow_q == 3'd0;
        state_d = CHECK;
      end
      CHECK: if (etc_q == '0) begin
        err_d = 1'b1; first_d = 1'b0; rde_d = 1'b0; state_d = IDLE;
      end else begin
        launched_d = launch_set; got_d = '0;
        conv_start_d = 1'b1; conv_first_d = launch_set[1];
        infm_start_d = launch_set[1]; sh_start_d = launch_set[2];
        sh_row_d = row_q + row_width'(num_pe_row) + row_width'(krow_q);
        state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        got_d = got_q | (task_done & launched_q);
        if ((got_d | ~launched_q) == 3'b111) begin
          if (more_rows) begin
            krow_d = krow_q + 3'd1; first_d = 1'b0; state_d = LOAD;
          end else begin
            done_d = 1'b1; first_d = 1'b0; rde_d = 1'b0; state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; krow_q <= '0; ks_q <= '0; nap_q <= '0; row_q <= '0; sh_row_q <= '0;
      wtap_q <= '0; bpr_q <= '0; etc_q <= '0; launched_q <= '0; got_q <= '0;
      which_q <= 1'b0; rde_q <= 1'b0; first_q <= 1'b0;
      conv_start_q <= 1'b0; conv_first_q <= 1'b0; infm_start_q <= 1'b0; sh_start_q <= 1'b0;
      done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; krow_q <= krow_d; ks_q <= ks_d; nap_q <= nap_d; row_q <= row_d; sh_row_q <= sh_row_d;
      wtap_q <= wtap_d; bpr_q <= bpr_d; etc_q <= etc_d; launched_q <= launched_d; got_q <= got_d;
      which_q <= which_d; rde_q <= rde_d; first_q <= first_d;
      conv_start_q <= conv_start_d; conv_first_q <= conv_first_d; infm_start_q <= infm_start_d;
      sh_start_q <= sh_start_d; done_q <= done_d; err_q <= err_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) store_q[i] <= '0;
    end else if (w_wr_en_i && state_q == IDLE && int'(w_wr_addr_i) < depth) begin
      store_q[w_wr_addr_i] <= w_wr_data_i;
    end
  end
  assign WRegs_o = {num_pe_col{wtap_q}};
  assign WBPRs_o = {num_pe_col{bpr_q}};
  assign WETCs_o = {num_pe_col{etc_q}};
  assign row_conv_start_o = conv_start_q;
  assign row_conv_first_o = conv_first_q;
  assign infm_load_start_o = infm_start_q;
  assign infm_load_row_o = row_q;
  assign shadow_start_o = sh_start_q;
  assign shadow_row_o = sh_row_q;
  assign first_acc_flag_o = first_q;
  assign pe_ctrl_which_afifo_for_compute_o = {n_pe{which_q}};
  assign pe_ctrl_compute_AFIFO_read_delay_enable_o = {n_pe{rde_q}};
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign error_o = err_q;
endmodule

// File: tb/tb_dw_conv_krow_sequencer.sv
// tb_dw_conv_krow_sequencer: directed and table-driven checks of the kernel-row sequencer.
module tb_dw_conv_krow_sequencer;
  localparam int NC = 4, NT = 11, WW = 16, BW = 24, EW = 4;
  logic clk = 0, rst_n = 0, start = 0, w_wr_en = 0;
  logic [2:0] kernel_size = 0;
  logic [3:0] n_ap = 0;
  logic [15:0] infm_start_row = 0, w_wr_data = 0;
  logic [4:0] w_wr_addr = 0;
  logic [NC*WW*NT-1:0] wregs;
  logic [NC*BW*NT-1:0] wbprs;
  logic [NC*EW*NT-1:0] wetcs;
  logic row_conv_start, row_conv_first, infm_load_start, shadow_start;
  logic row_conv_done = 0, infm_load_done = 0, shadow_done = 0;
  logic [15:0] infm_load_row, shadow_row, which, rde;
  logic first_acc, busy, done, error;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, launch_cnt = 0;
  typedef struct {
    logic [15:0] w;
    logic [3:0]  nap;
    logic [23:0] bpr;
    logic [3:0]  etc;
  } vec_t;
  vec_t tbl[8];
  dw_conv_krow_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .kernel_size_i(kernel_size), .n_ap_i(n_ap),
    .infm_start_row_i(infm_start_row), .w_wr_en_i(w_wr_en), .w_wr_addr_i(w_wr_addr),
    .w_wr_data_i(w_wr_data), .WRegs_o(wregs), .WBPRs_o(wbprs), .WETCs_o(wetcs),
    .row_conv_start_o(row_conv_start), .row_conv_first_o(row_conv_first),
    .row_conv_done_i(row_conv_done), .infm_load_start_o(infm_load_start),
    .infm_load_row_o(infm_load_row), .infm_load_done_i(infm_load_done),
    .shadow_start_o(shadow_start), .shadow_row_o(shadow_row), .shadow_done_i(shadow_done),
    .first_acc_flag_o(first_acc), .pe_ctrl_which_afifo_for_compute_o(which),
    .pe_ctrl_compute_AFIFO_read_delay_enable_o(rde), .busy_o(busy), .done_o(done), .error_o(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    done_cnt += int'(done);
    err_cnt += int'(error);
    launch_cnt += int'(row_conv_start);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    w_wr_en = 1; w_wr_addr = a; w_wr_data = d;
    tick();
    w_wr_en = 0;
  endtask
  task automatic go(input logic [2:0] ks, input logic [3:0] nap, input logic [15:0] row);
    kernel_size = ks; n_ap = nap; infm_start_row = row; start = 1;
    tick();
    start = 0;
  endtask
  task automatic chk_w(input logic [15:0] t0, t1, t2);
    logic [WW*NT-1:0] e;
    e = '0; e[15:0] = t0; e[31:16] = t1; e[47:32] = t2;
    for (int c = 0; c < NC; c++) chk($sformatf("wregs_col%0d", c), wregs[c*WW*NT +: WW*NT], e);
  endtask
  task automatic chk_be(input logic [23:0] b0, input logic [3:0] e0);
    logic [BW*NT-1:0] b;
    logic [EW*NT-1:0] e;
    b = '0; b[23:0] = b0; e = '0; e[3:0] = e0;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("wbprs_col%0d", c), wbprs[c*BW*NT +: BW*NT], b);
      chk($sformatf("wetcs_col%0d", c), wetcs[c*EW*NT +: EW*NT], e);
    end
  endtask
  // Waits for a launch, checks it, then answers with split done pulses (conv first, then the rest).
  task automatic serve_row(input logic ef, es, input logic [15:0] esr, erow, input logic ew, er, el, ign);
    int n = 0;
    while (!row_conv_start && n < 20) begin tick(); n++; end
    chk("launch_seen", row_conv_start, 1);
    chk("conv_first", row_conv_first, ef);
    chk("infm_start", infm_load_start, ef);
    if (ef) chk("infm_row", infm_load_row, erow);
    chk("shadow_start", shadow_start, es);
    if (es) chk("shadow_row", shadow_row, esr);
    chk("which_afifo", which, {16{ew}});
    chk("rd_delay_en", rde, {16{er}});
    chk("first_acc", first_acc, ef);
    if (ign) begin row_conv_done = 1; infm_load_done = 1; shadow_done = 1; end
    tick();
    {row_conv_done, infm_load_done, shadow_done} = 3'b000;
    if (ign) begin
      tick(); tick();
      chk("launch_cycle_done_ignored", {busy, done}, 2'b10);
    end
    row_conv_done = 1;
    tick();
    row_conv_done = 0;
    if (ef || es) begin
      infm_load_done = ef; shadow_done = 1;
      tick();
      {infm_load_done, shadow_done} = 2'b00;
    end
    if (el) begin
      chk("done_pulse", done, 1);
      chk("first_acc_end", first_acc, 0);
      chk("rde_end", rde, 0);
      tick();
      chk("done_one_cycle_idle", {done, busy}, 2'b00);
    end
  endtask
  initial begin
    int d0, e0, l0, n;
    logic [2:0] bad_ks[3];
    tbl[0] = '{16'h00FF, 4'd0, 24'h001FFE, 4'd2};
    tbl[1] = '{16'h00FF, 4'd2, 24'h001FC0, 4'd1};
    tbl[2] = '{16'h0001, 4'd0, 24'h000002, 4'd1};
    tbl[3] = '{16'hFFFF, 4'd0, 24'hFFFFFE, 4'd1};
    tbl[4] = '{16'h8000, 4'd0, 24'h800000, 4'd1};
    tbl[5] = '{16'h5555, 4'd0, 24'h492492, 4'd8};
    tbl[6] = '{16'h0003, 4'd0, 24'h00000E, 4'd2};
    tbl[7] = '{16'h5555, 4'd8, 24'h000000, 4'd0};
    bad_ks[0] = 3'd0; bad_ks[1] = 3'd6; bad_ks[2] = 3'd7;
    #12;
    chk("reset_outputs", {busy, done, error, first_acc, row_conv_start, infm_load_start, shadow_start, which, rde}, 0);
    chk("reset_rows", {infm_load_row, shadow_row}, 0);
    chk_w(0, 0, 0);
    rst_n = 1;
    tick();
    // 3x3 all-ones kernel; a busy-time write and a busy-time start must both be ignored
    for (int a = 0; a < 9; a++) wr(5'(a), 16'd1);
    d0 = done_cnt; e0 = err_cnt; l0 = launch_cnt;
    go(3, 0, 0);
    tick();
    chk_w(1, 1, 1);
    serve_row(1, 1, 16'd4, 16'd0, 0, 1, 0, 0);
    w_wr_en = 1; w_wr_addr = 0; w_wr_data = 16'd7; start = 1; kernel_size = 0;
    serve_row(0, 1, 16'd5, 16'd0, 1, 1, 0, 0);
    w_wr_en = 0; start = 0;
    serve_row(0, 0, 16'd0, 16'd0, 0, 0, 1, 0);
    chk("k3_done_count", done_cnt - d0, 1);
    chk("k3_no_error", err_cnt - e0, 0);
    chk("k3_launch_count", launch_cnt - l0, 3);
    // kernel row 1 all zero: abort in the second CHECK
    for (int a = 3; a < 6; a++) wr(5'(a), 16'd0);
    l0 = launch_cnt;
    go(3, 0, 16'd10);
    tick();
    chk_w(1, 1, 1);
    serve_row(1, 1, 16'd14, 16'd10, 0, 1, 0, 0);
    n = 0;
    while (!error && !row_conv_start && n < 20) begin tick(); n++; end
    chk("zero_row_error", error, 1);
    chk("zero_row_no_launch", launch_cnt - l0, 1);
    chk("zero_row_idle", {busy, first_acc}, 2'b00);
    chk("zero_row_rde", rde, 0);
    tick();
    chk("zero_row_error_pulse", error, 0);
    // kernel_size=1 encoding table; which_afifo stays 1 from the aborted run
    for (int i = 0; i < 8; i++) begin
      wr(0, tbl[i].w);
      go(1, tbl[i].nap, 16'h20);
      tick();
      chk_w(tbl[i].w, 0, 0);
      chk_be(tbl[i].bpr, tbl[i].etc);
      if (tbl[i].etc != 0) serve_row(1, 0, 16'd0, 16'h20, 1, 0, 1, i == 0);
      else begin
        tick();
        chk("etc_zero_error", {error, busy}, 2'b10);
      end
    end
    // illegal kernel sizes
    foreach (bad_ks[k]) begin
      go(bad_ks[k], 0, 0);
      chk($sformatf("bad_ks%0d_error", bad_ks[k]), {error, busy}, 2'b10);
      tick();
      chk($sformatf("bad_ks%0d_idle", bad_ks[k]), {error, busy}, 2'b00);
    end
    // asynchronous reset during krow1 WAIT
    for (int a = 3; a < 6; a++) wr(5'(a), 16'd1);
    d0 = done_cnt;
    go(3, 0, 0);
    serve_row(1, 1, 16'd4, 16'd0, 1, 1, 0, 0);
    n = 0;
    while (!row_conv_start && n < 20) begin tick(); n++; end
    chk("rst_row1_launch", row_conv_start, 1);
    tick();
    #1 rst_n = 0;
    #1;
    chk("rst_async_outputs", {busy, done, error, first_acc, which, rde}, 0);
    chk("rst_async_rows", {infm_load_row, shadow_row}, 0);
    chk_w(0, 0, 0);
    #2 rst_n = 1;
    row_conv_done = 1;
    tick();
    row_conv_done = 0;
    tick();
    chk("rst_late_done_ignored", {busy, done}, 2'b00);
    chk("rst_no_done_pulse", done_cnt - d0, 0);
    go(1, 0, 0);
    tick();
    chk_w(0, 0, 0);
    tick();
    chk("rst_store_cleared_error", error, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
